// File: rtl/pulse_stretcher_pkg.sv
// Shared types and helpers for the LED pulse stretcher and related display blocks.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Elaboration-time ceil(log2(value)); callers pass values >= 2.
  function automatic int clog2_f(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      rem    = rem >> 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// Event/status bundle between a pulse source and the LED stretcher.
interface pulse_stretcher_if #(
  parameter int QUEUE_W = 3
);
  logic               evt;
  logic               clr_ovf;
  logic               led;
  logic               busy;
  logic [QUEUE_W-1:0] pending;
  logic               ovf;

  modport master (output evt, output clr_ovf, input led, input busy, input pending, input ovf);
  modport slave  (input evt, input clr_ovf, output led, output busy, output pending, output ovf);
endinterface

// File: rtl/pulse_stretcher_tick_gen.sv
// Free-running prescaler emitting a one-cycle tick every CLK_DIV cycles; clr restarts the count.
module tick_gen
  import pulse_stretcher_pkg::*;
#(
  parameter int CLK_DIV = 250_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int            PW        = clog2_f(CLK_DIV);
  localparam logic [PW-1:0] PRESC_END = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);

  logic [PW-1:0] presc_r;

  // Prescaler register: wraps at terminal count, restarts on clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= '0;
    end else if (clr || (presc_r == PRESC_END)) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PRESC_ONE;
    end
  end

  assign tick = (presc_r == PRESC_END);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into ON/GAP LED flashes, queueing events that arrive mid-flash.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int CLK_DIV   = 250_000,
  parameter int ON_TICKS  = 50,
  parameter int GAP_TICKS = 25,
  parameter int QUEUE_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  pulse_stretcher_if.slave  bus
);

  localparam int                 MAX_TICKS = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int                 TW        = clog2_f(MAX_TICKS + 1);
  localparam logic [TW-1:0]      ON_LAST   = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0]      GAP_LAST  = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0]      TCNT_ONE  = TW'(1);
  localparam logic [QUEUE_W-1:0] PEND_MAX  = '1;
  localparam logic [QUEUE_W-1:0] PEND_ONE  = QUEUE_W'(1);

  state_e             state_r, state_s;
  logic [TW-1:0]      tcnt_r, tcnt_s;
  logic [QUEUE_W-1:0] pend_r, pend_s;
  logic               ovf_r, ovf_s;
  logic               led_r, busy_r;
  logic               tick_s, clr_s, enq_s, deq_s, sat_s;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .tick  (tick_s)
  );

  // Next-state, queue and overflow decisions.
  always_comb begin
    state_s = state_r;
    enq_s   = 1'b0;
    deq_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.evt) state_s = ST_ON;
        else         state_s = ST_IDLE;
      end
      ST_ON: begin
        enq_s = bus.evt;
        if (tick_s && (tcnt_r == ON_LAST)) state_s = ST_GAP;
        else                               state_s = ST_ON;
      end
      ST_GAP: begin
        if (tick_s && (tcnt_r == GAP_LAST)) begin
          // An event landing on the dequeue cycle replaces the dequeued one.
          if (pend_r != '0) begin
            state_s = ST_ON;
            deq_s   = !bus.evt;
          end else if (bus.evt) begin
            state_s = ST_ON;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          enq_s   = bus.evt;
          state_s = ST_GAP;
        end
      end
      default: state_s = ST_IDLE;
    endcase

    sat_s = enq_s && (pend_r == PEND_MAX);
    if (enq_s && !sat_s) pend_s = pend_r + PEND_ONE;
    else if (deq_s)      pend_s = pend_r - PEND_ONE;
    else                 pend_s = pend_r;

    if (sat_s)            ovf_s = 1'b1;
    else if (bus.clr_ovf) ovf_s = 1'b0;
    else                  ovf_s = ovf_r;

    clr_s = (state_s != state_r) || (state_r == ST_IDLE);
    if (clr_s)       tcnt_s = '0;
    else if (tick_s) tcnt_s = tcnt_r + TCNT_ONE;
    else             tcnt_s = tcnt_r;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      tcnt_r  <= '0;
      pend_r  <= '0;
      ovf_r   <= 1'b0;
      led_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      tcnt_r  <= tcnt_s;
      pend_r  <= pend_s;
      ovf_r   <= ovf_s;
      led_r   <= (state_s == ST_ON);
      busy_r  <= (state_s != ST_IDLE);
    end
  end

  assign bus.led     = led_r;
  assign bus.busy    = busy_r;
  assign bus.pending = pend_r;
  assign bus.ovf     = ovf_r;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: flash-schedule model checked every cycle plus literal spot checks.
module tb_pulse_stretcher;

  localparam int CLK_DIV   = 4;
  localparam int ON_TICKS  = 3;
  localparam int GAP_TICKS = 2;
  localparam int QUEUE_W   = 2;
  localparam int ON_LEN    = ON_TICKS * CLK_DIV;
  localparam int TOTAL     = (ON_TICKS + GAP_TICKS) * CLK_DIV;
  localparam int PMAX      = (1 << QUEUE_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pulse_stretcher_if #(.QUEUE_W(QUEUE_W)) bus ();

  pulse_stretcher #(
    .CLK_DIV   (CLK_DIV),
    .ON_TICKS  (ON_TICKS),
    .GAP_TICKS (GAP_TICKS),
    .QUEUE_W   (QUEUE_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a flash is identified by the edge index at which it started; everything else is arithmetic.
  int k = 0, s = 0, m_pend = 0, p = 0;
  bit act = 1'b0, m_ovf = 1'b0, sat = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      k = 0; s = 0; act = 1'b0; m_pend = 0; m_ovf = 1'b0;
    end else begin
      p   = k - s;
      sat = 1'b0;
      if (!act || p >= TOTAL) begin
        if (bus.evt) begin act = 1'b1; s = k + 1; end
      end else if (p == TOTAL - 1) begin
        if (m_pend > 0) begin
          s = k + 1;
          if (!bus.evt) m_pend--;
        end else if (bus.evt) begin
          s = k + 1;
        end
      end else if (bus.evt) begin
        if (m_pend == PMAX) sat = 1'b1;
        else m_pend++;
      end
      if (sat) m_ovf = 1'b1;
      else if (bus.clr_ovf) m_ovf = 1'b0;
      k++;
    end
  end

  initial forever begin
    @(negedge clk);
    check("cyc_led",  int'(bus.led),     (act && (k - s) < ON_LEN) ? 1 : 0);
    check("cyc_busy", int'(bus.busy),    (act && (k - s) < TOTAL) ? 1 : 0);
    check("cyc_pend", int'(bus.pending), m_pend);
    check("cyc_ovf",  int'(bus.ovf),     int'(m_ovf));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    bus.evt = 1'b1;
    step(1);
    bus.evt = 1'b0;
  endtask

  // Runs until idle (bounded), counting new flashes; an expired bound shows up as busy still high.
  task automatic wait_idle(input string name, output int flashes);
    int  n;
    bit  prev;
    n       = 0;
    flashes = 0;
    prev    = bus.led;
    while (bus.busy && n < 400) begin
      step(1);
      if (bus.led && !prev) flashes++;
      prev = bus.led;
      n++;
    end
    check(name, int'(bus.busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  int fl;

  initial begin
    bus.evt     = 1'b0;
    bus.clr_ovf = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);
    check("rst_led",  int'(bus.led), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_pend", int'(bus.pending), 0);
    check("rst_ovf",  int'(bus.ovf), 0);

    // Single flash: led 12 cycles, busy 20 cycles.
    pulse();
    check("t2_led_first", int'(bus.led), 1);
    step(11);
    check("t2_led_last", int'(bus.led), 1);
    step(1);
    check("t2_led_off", int'(bus.led), 0);
    check("t2_busy_gap", int'(bus.busy), 1);
    step(7);
    check("t2_busy_last", int'(bus.busy), 1);
    step(1);
    check("t2_idle", int'(bus.busy), 0);
    check("t2_pend", int'(bus.pending), 0);
    step(2);

    // Events at t, t+5, t+15.
    pulse();
    step(4);
    pulse();
    check("t3_pend1", int'(bus.pending), 1);
    step(9);
    pulse();
    check("t3_pend2", int'(bus.pending), 2);
    step(5);
    check("t3_flash2_led", int'(bus.led), 1);
    check("t3_flash2_pend", int'(bus.pending), 1);
    step(20);
    check("t3_flash3_led", int'(bus.led), 1);
    check("t3_flash3_pend", int'(bus.pending), 0);
    wait_idle("t3_idle", fl);

    // Five queued events saturate the counter and set ovf.
    pulse();
    for (int i = 0; i < 5; i++) begin
      step(1);
      pulse();
    end
    check("t4_pend_sat", int'(bus.pending), 3);
    check("t4_ovf_set", int'(bus.ovf), 1);
    bus.clr_ovf = 1'b1;
    step(1);
    bus.clr_ovf = 1'b0;
    check("t4_ovf_clr", int'(bus.ovf), 0);
    wait_idle("t4_idle", fl);
    check("t4_flashes", fl, 3);

    // Event on the GAP terminal cycle with nothing queued.
    pulse();
    step(11);
    check("t5_led_last_on", int'(bus.led), 1);
    step(1);
    check("t5_led_gap_first", int'(bus.led), 0);
    step(7);
    check("t5_led_gap_last", int'(bus.led), 0);
    pulse();
    check("t5_restart_led", int'(bus.led), 1);
    check("t5_restart_pend", int'(bus.pending), 0);
    // Same with one event queued: the queue depth is unchanged.
    step(2);
    pulse();
    check("t5b_pend1", int'(bus.pending), 1);
    step(16);
    pulse();
    check("t5b_led", int'(bus.led), 1);
    check("t5b_pend", int'(bus.pending), 1);
    wait_idle("t5b_idle", fl);
    check("t5b_flashes", fl, 1);

    // evt held for three cycles from IDLE.
    bus.evt = 1'b1;
    step(3);
    bus.evt = 1'b0;
    check("t6_pend", int'(bus.pending), 2);
    check("t6_led", int'(bus.led), 1);
    wait_idle("t6_idle", fl);
    check("t6_flashes", fl, 2);

    // Asynchronous reset in the middle of a flash with a queued event.
    pulse();
    step(3);
    pulse();
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_led", int'(bus.led), 0);
    check("t1_busy", int'(bus.busy), 0);
    check("t1_pend", int'(bus.pending), 0);
    check("t1_ovf", int'(bus.ovf), 0);
    step(2);
    rst_n = 1'b1;
    step(3);
    check("t1_after_busy", int'(bus.busy), 0);
    pulse();
    wait_idle("t1_final_idle", fl);
    check("t1_final_pend", int'(bus.pending), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
